if_fetch_stage: RTL and testbench

- Instruction-fetch stage directly downstream of the program-counter register.
- Takes the current `pc`, issues in-order requests to instruction memory, and drives the PC enable so the PC advances only when a request is accepted or a redirect occurs.
- Tags returning instruction words with their fetch address and buffers them.
- Hands `{pc, inst}` pairs to decode over a valid/ready interface. Handles redirect flushes, including discarding stale in-flight responses.

---
 rtl/if_fetch_stage.sv | 133 +++++++++++++
 tb/tb_if_fetch_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues in-order fetches at the current PC, tags the returning
// words with their address, and presents {pc, inst} pairs to decode over valid/ready.
module if_fetch_stage #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic        pc_en_o,
  input  logic        flush_i,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = CW + 2;
  localparam logic [OW-1:0] CAP = OW'(DEPTH);

  typedef logic [CW-1:0] cnt_t;

  logic [31:0]   tag_mem [DEPTH];
  logic [AW-1:0] tag_wr;
  logic [AW-1:0] tag_rd;
  cnt_t          tag_cnt;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] inst_wr;
  logic [AW-1:0] inst_rd;
  cnt_t          inst_cnt;

  cnt_t          drop_cnt;

  logic          req_fire_p0;
  logic [OW-1:0] occ_p0;
  logic          resp_push_p1;
  logic          vld_p2;
  logic          id_pop_p2;

  // Slots claimed by requests in flight, buffered words and pending discards. An entry
  // leaving for decode this cycle frees its slot now, which is what lets a DEPTH=2 stage
  // keep one request in flight and one word buffered while streaming at full rate.
  function automatic logic [OW-1:0] occupancy(cnt_t inflight, cnt_t buffered, cnt_t drop,
                                              logic pop);
    return OW'(inflight) + OW'(buffered) + OW'(drop) - OW'(pop);
  endfunction

  // Every request still in flight at a redirect becomes a discard, except a response that
  // lands in the redirect cycle itself, which is thrown away on the spot.
  function automatic cnt_t flush_drop(cnt_t drop, cnt_t inflight, logic resp);
    return drop + inflight - cnt_t'(resp);
  endfunction

  // Stage 0: request issue and PC advance
  assign occ_p0         = occupancy(tag_cnt, inst_cnt, drop_cnt, id_pop_p2);
  assign imem_req_valid = rst && !flush_i && (occ_p0 < CAP);
  assign imem_req_addr  = pc_i;
  assign req_fire_p0    = imem_req_valid && imem_req_ready;
  assign pc_en_o        = rst && (flush_i || req_fire_p0);

  // Stage 1: response tagging or discard
  assign resp_push_p1 = imem_resp_valid && !flush_i && (drop_cnt == '0);

  // Stage 2: decode hand-off
  assign vld_p2    = (inst_cnt != '0);
  assign id_pop_p2 = vld_p2 && id_ready;
  assign id_valid  = vld_p2;
  assign id_pc     = vld_p2 ? pc_mem[inst_rd]   : 32'h0;
  assign id_inst   = vld_p2 ? inst_mem[inst_rd] : NOP_INST;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_wr   <= '0;
      tag_rd   <= '0;
      tag_cnt  <= '0;
      inst_wr  <= '0;
      inst_rd  <= '0;
      inst_cnt <= '0;
      drop_cnt <= '0;
    end else if (flush_i) begin
      tag_wr   <= '0;
      tag_rd   <= '0;
      tag_cnt  <= '0;
      inst_wr  <= '0;
      inst_rd  <= '0;
      inst_cnt <= '0;
      drop_cnt <= flush_drop(drop_cnt, tag_cnt, imem_resp_valid);
    end else begin
      if (req_fire_p0) begin
        tag_wr <= tag_wr + AW'(1);
      end
      if (resp_push_p1) begin
        tag_rd  <= tag_rd + AW'(1);
        inst_wr <= inst_wr + AW'(1);
      end
      if (id_pop_p2) begin
        inst_rd <= inst_rd + AW'(1);
      end
      tag_cnt  <= tag_cnt + cnt_t'(req_fire_p0) - cnt_t'(resp_push_p1);
      inst_cnt <= inst_cnt + cnt_t'(resp_push_p1) - cnt_t'(id_pop_p2);
      if (imem_resp_valid && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire_p0) begin
      tag_mem[tag_wr] <= pc_i;
    end
    if (resp_push_p1) begin
      pc_mem[inst_wr]   <= tag_mem[tag_rd];
      inst_mem[inst_wr] <= imem_resp_data;
    end
  end

  // A response with nothing outstanding means the memory broke the protocol.
  orphan_resp_a: assert property (@(posedge clk) disable iff (!rst)
    !(imem_resp_valid && (tag_cnt == '0) && (drop_cnt == '0)));

  capacity_a: assert property (@(posedge clk) disable iff (!rst)
    (OW'(tag_cnt) + OW'(inst_cnt) + OW'(drop_cnt)) <= CAP);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: PC register and in-order memory models around the
// DUT, with a scoreboard of expected {pc, inst} pairs checked as decode consumes them.
module tb_if_fetch_stage;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_en_o;
  logic        flush_i;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  logic [31:0] flush_target;
  int          lat;
  int          passed = 0;
  int          total  = 0;
  int          fires  = 0;
  int          cyc;

  typedef struct {logic [31:0] pc; logic [31:0] inst;} exp_t;
  typedef struct {logic [31:0] a; int due;} mreq_t;

  exp_t        expq[$];
  exp_t        sb_e;
  logic [31:0] exp_next;
  mreq_t       mq[$];

  if_fetch_stage #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_i           (pc_i),
    .pc_en_o        (pc_en_o),
    .flush_i        (flush_i),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_inst        (id_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
  endtask

  task automatic wait_valid(int maxc);
    int n = 0;
    while (!id_valid && n < maxc) begin
      step(1);
      n++;
    end
    chk("wait_valid", {31'b0, id_valid}, 32'd1);
  endtask

  // PC register: loads the redirect target on a flush, otherwise pc+4 when enabled
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_i <= RESET_PC;
    else if (pc_en_o) pc_i <= flush_i ? flush_target : pc_i + 32'd4;
  end

  // In-order memory answering each accepted request lat cycles later
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      cyc             <= 0;
      imem_resp_valid <= 1'b0;
      imem_resp_data  <= 32'h0;
    end else begin
      cyc <= cyc + 1;
      if (imem_req_valid && imem_req_ready) mq.push_back('{imem_req_addr, cyc + lat});
      if (mq.size() != 0 && mq[0].due <= cyc + 1) begin
        imem_resp_valid <= 1'b1;
        imem_resp_data  <= memf(mq[0].a);
        void'(mq.pop_front());
      end else begin
        imem_resp_valid <= 1'b0;
        imem_resp_data  <= 32'h0;
      end
    end
  end

  // Scoreboard: expectations pushed at request acceptance, compared at decode pop
  always @(negedge clk) begin
    if (!rst) begin
      expq.delete();
      exp_next = RESET_PC;
      fires    = 0;
    end else if (flush_i) begin
      chk("flush_noreq", {31'b0, imem_req_valid}, 32'd0);
      expq.delete();
      exp_next = flush_target;
    end else begin
      if (id_valid && id_ready) begin
        chk("sb_nonempty", {31'b0, expq.size() != 0}, 32'd1);
        if (expq.size() != 0) begin
          sb_e = expq.pop_front();
          chk("sb_id_pc", id_pc, sb_e.pc);
          chk("sb_id_inst", id_inst, sb_e.inst);
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("sb_req_addr", imem_req_addr, exp_next);
        expq.push_back('{exp_next, memf(exp_next)});
        exp_next = exp_next + 32'd4;
        fires    = fires + 1;
      end
    end
  end

  initial begin
    rst            = 1'b1;
    flush_i        = 1'b0;
    id_ready       = 1'b1;
    imem_req_ready = 1'b1;
    flush_target   = 32'h0;
    lat            = 1;
    #2 rst = 1'b0;
    #1;
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_inst", id_inst, NOP);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_pc_en", {31'b0, pc_en_o}, 32'd0);
    step(2);
    release_rst();

    // streaming fill and full-rate throughput
    chk("c0_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("c0_req_addr", imem_req_addr, RESET_PC);
    chk("c0_pc_en", {31'b0, pc_en_o}, 32'd1);
    step(1);
    chk("c1_id_valid", {31'b0, id_valid}, 32'd0);
    step(1);
    chk("c2_id_valid", {31'b0, id_valid}, 32'd1);
    chk("c2_id_pc", id_pc, RESET_PC);
    step(1);
    chk("c3_id_pc", id_pc, RESET_PC + 32'd4);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("thru_valid", {31'b0, id_valid}, 32'd1);
    end

    // asynchronous reset mid-stream, then decode stalled from the start
    rst = 1'b0;
    #1;
    chk("mr_id_valid", {31'b0, id_valid}, 32'd0);
    chk("mr_id_pc", id_pc, 32'h0);
    chk("mr_id_inst", id_inst, NOP);
    chk("mr_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("mr_pc_en", {31'b0, pc_en_o}, 32'd0);
    id_ready = 1'b0;
    release_rst();
    step(6);
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("stall_pc_en", {31'b0, pc_en_o}, 32'd0);
    chk("stall_pc_hold", imem_req_addr, RESET_PC + 32'd8);
    chk("stall_head", id_pc, RESET_PC);
    chk("stall_fires", fires, 32'd2);
    id_ready = 1'b1;
    step(8);
    chk("stall_resume", {31'b0, fires > 4}, 32'd1);

    // memory ready toggling
    for (int i = 0; i < 10; i++) begin
      step(1);
      imem_req_ready = i[0];
      #1;
      if (!imem_req_ready) chk("tog_en_low", {31'b0, pc_en_o}, 32'd0);
      else chk("tog_en_high", {31'b0, pc_en_o}, {31'b0, imem_req_valid});
    end
    imem_req_ready = 1'b1;
    step(6);

    // flush with one request in flight and one word buffered; stale response dropped
    rst      = 1'b0;
    lat      = 2;
    id_ready = 1'b0;
    step(2);
    release_rst();
    step(1);
    imem_req_ready = 1'b0;
    step(1);
    imem_req_ready = 1'b1;
    step(1);
    chk("fl_buffered", {31'b0, id_valid}, 32'd1);
    chk("fl_head", id_pc, RESET_PC);
    flush_target = 32'h0040_0100;
    flush_i      = 1'b1;
    #1;
    chk("fl_pc_en", {31'b0, pc_en_o}, 32'd1);
    chk("fl_req_valid", {31'b0, imem_req_valid}, 32'd0);
    step(1);
    flush_i  = 1'b0;
    lat      = 1;
    id_ready = 1'b1;
    chk("fl_id_valid_next", {31'b0, id_valid}, 32'd0);
    wait_valid(10);
    chk("fl_first_pc", id_pc, 32'h0040_0100);
    chk("fl_first_inst", id_inst, memf(32'h0040_0100));
    step(6);

    // flush coinciding with a response arrival and a decode pop
    chk("co_id_valid", {31'b0, id_valid}, 32'd1);
    chk("co_resp", {31'b0, imem_resp_valid}, 32'd1);
    flush_target = 32'h0040_0200;
    flush_i      = 1'b1;
    step(1);
    flush_i = 1'b0;
    chk("co_id_valid_next", {31'b0, id_valid}, 32'd0);
    wait_valid(10);
    chk("co_first_pc", id_pc, 32'h0040_0200);
    chk("co_first_inst", id_inst, memf(32'h0040_0200));
    step(6);
    chk("co_stream_pc", id_pc, exp_next - 32'd8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
